// File: rtl/mux_sel_skid.sv
// Pipelined N-input operand selector with a two-entry skid buffer on a valid/ready output.
// Out-of-range selects fall back to input 0 and are flagged and counted.
module mux_sel_skid #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] w_main_data_nxt;
  logic             r_main_err;
  logic             w_main_err_nxt;
  logic [WIDTH-1:0] r_skid_data;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             r_skid_err;
  logic             w_skid_err_nxt;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] w_err_count_nxt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_main_valid;
  logic             w_skid_valid;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_emit;

  // Operand select; anything outside 0..NUM_IN-1 keeps the slice-0 default and flags an error.
  always_comb begin
    w_sel_data = in_data[WIDTH-1:0];
    w_sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign w_main_valid = (r_state != S_EMPTY);
  assign w_skid_valid = (r_state == S_TWO);
  assign w_in_ready   = !w_skid_valid && !flush && !rst;
  assign w_accept     = in_valid && w_in_ready;
  assign w_emit       = w_main_valid && out_ready;

  // Next-state and storage update.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_err_nxt  = r_main_err;
    w_skid_data_nxt = r_skid_data;
    w_skid_err_nxt  = r_skid_err;
    w_err_count_nxt = r_err_count;

    if (w_accept && w_sel_err && (r_err_count != {CNT_W{1'b1}})) begin
      w_err_count_nxt = r_err_count + CNT_W'(1);
    end

    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = w_sel_data;
            w_main_err_nxt  = w_sel_err;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            w_main_data_nxt = w_sel_data;
            w_main_err_nxt  = w_sel_err;
          end else if (w_accept) begin
            w_state_nxt     = S_TWO;
            w_skid_data_nxt = w_sel_data;
            w_skid_err_nxt  = w_sel_err;
          end else if (w_emit) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_err_nxt  = r_skid_err;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_err  <= w_main_err_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_err  <= w_skid_err_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_main_valid;
  assign out_data    = r_main_data;
  assign out_sel_err = r_main_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_mux_sel_skid.sv
// Scoreboard bench for mux_sel_skid: directed 16-bit/3-input checks plus 32-bit/4-input traffic.
module tb_mux_sel_skid;

  localparam int unsigned AW = 16;
  localparam int unsigned AN = 3;
  localparam int unsigned BW = 32;
  localparam int unsigned BN = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst;

  logic [AN*AW-1:0] a_in_data;
  logic [SW-1:0]    a_in_sel;
  logic             a_in_valid, a_in_ready, a_flush;
  logic [AW-1:0]    a_out_data;
  logic             a_out_sel_err, a_out_valid, a_out_ready;
  logic [7:0]       a_err_count;

  logic [BN*BW-1:0] b_in_data;
  logic [SW-1:0]    b_in_sel;
  logic             b_in_valid, b_in_ready, b_flush;
  logic [BW-1:0]    b_out_data;
  logic             b_out_sel_err, b_out_valid, b_out_ready;
  logic [7:0]       b_err_count;

  int checks = 0;
  int errors = 0;
  int b_acc_cnt = 0;

  logic [AW:0]   a_q[$];
  logic [BW:0]   b_q[$];
  logic [AW:0]   a_e;
  logic [BW:0]   b_e;
  logic [AW-1:0] a_exp_data;
  logic          a_exp_err;
  logic [BW-1:0] b_exp_data;
  logic [BW-1:0] b_w[BN];

  localparam logic [AN*AW-1:0] D1 = {16'h3333, 16'h2222, 16'h1111};
  localparam logic [AN*AW-1:0] D2 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
  localparam logic [AN*AW-1:0] D3 = {16'h3333, 16'h2222, 16'hBEEF};

  mux_sel_skid #(.WIDTH(AW), .NUM_IN(AN), .SEL_W(SW)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data), .out_sel_err(a_out_sel_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .err_count(a_err_count)
  );

  mux_sel_skid #(.WIDTH(BW), .NUM_IN(BN), .SEL_W(SW)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_sel_err(b_out_sel_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .err_count(b_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [SW-1:0] sel, input logic [AN*AW-1:0] d,
                         input logic [AW-1:0] ed, input logic ee);
    a_in_valid = v;
    a_in_sel   = sel;
    a_in_data  = d;
    a_exp_data = ed;
    a_exp_err  = ee;
  endtask

  // Scoreboard A: pop on delivery, then push on acceptance, both sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected: got beat 0x%0h, expected none at %0t", a_out_data, $time);
        end else begin
          a_e = a_q.pop_front();
          check("a_scoreboard", 64'({a_out_sel_err, a_out_data}), 64'(a_e));
        end
      end
      if (a_in_valid && a_in_ready) a_q.push_back({a_exp_err, a_exp_data});
    end
  end

  // Scoreboard B: same scheme; every expected beat carries err = 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got beat 0x%0h, expected none at %0t", b_out_data, $time);
        end else begin
          b_e = b_q.pop_front();
          check("b_scoreboard", 64'({b_out_sel_err, b_out_data}), 64'(b_e));
        end
      end
      if (b_in_valid && b_in_ready) begin
        b_q.push_back({1'b0, b_exp_data});
        b_acc_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic new_beat;
    rst = 1'b1;
    drive_a(1'b0, '0, '0, '0, 1'b0);
    a_flush = 1'b0;
    a_out_ready = 1'b0;
    b_in_data = '0;
    b_in_sel = '0;
    b_in_valid = 1'b0;
    b_flush = 1'b0;
    b_out_ready = 1'b0;
    b_exp_data = '0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 64'(0));
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_out_data", 64'(a_out_data), 64'(0));
    check("rst_sel_err", 64'(a_out_sel_err), 64'(0));
    check("rst_err_count", 64'(a_err_count), 64'(0));
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(a_in_ready), 64'(1));
    tick();

    // Streaming, one-cycle latency
    a_out_ready = 1'b1;
    drive_a(1'b1, 2'd0, D1, 16'h1111, 1'b0);
    @(negedge clk);
    check("stream_ready0", 64'(a_in_ready), 64'(1));
    check("stream_valid0", 64'(a_out_valid), 64'(0));
    tick();
    drive_a(1'b1, 2'd1, D1, 16'h2222, 1'b0);
    @(negedge clk);
    check("stream_valid1", 64'(a_out_valid), 64'(1));
    check("stream_data1", 64'(a_out_data), 64'h1111);
    check("stream_ready1", 64'(a_in_ready), 64'(1));
    tick();
    drive_a(1'b1, 2'd2, D1, 16'h3333, 1'b0);
    @(negedge clk);
    check("stream_data2", 64'(a_out_data), 64'h2222);
    check("stream_ready2", 64'(a_in_ready), 64'(1));
    tick();
    drive_a(1'b0, 2'd0, D1, 16'h0, 1'b0);
    @(negedge clk);
    check("stream_data3", 64'(a_out_data), 64'h3333);
    check("stream_err3", 64'(a_out_sel_err), 64'(0));
    tick();
    @(negedge clk);
    check("stream_idle", 64'(a_out_valid), 64'(0));
    tick();

    // Stall: A, B buffered, C blocked until space frees
    a_out_ready = 1'b0;
    drive_a(1'b1, 2'd0, D2, 16'hAAAA, 1'b0);
    tick();
    drive_a(1'b1, 2'd1, D2, 16'hBBBB, 1'b0);
    @(negedge clk);
    check("stall_ready_b", 64'(a_in_ready), 64'(1));
    tick();
    drive_a(1'b1, 2'd2, D2, 16'hCCCC, 1'b0);
    @(negedge clk);
    check("stall_ready_low", 64'(a_in_ready), 64'(0));
    check("stall_hold_a", 64'(a_out_data), 64'hAAAA);
    tick();
    @(negedge clk);
    check("stall_hold_a2", 64'(a_out_data), 64'hAAAA);
    check("stall_valid", 64'(a_out_valid), 64'(1));
    tick();
    a_out_ready = 1'b1;
    @(negedge clk);
    check("stall_ready_two", 64'(a_in_ready), 64'(0));
    tick();
    @(negedge clk);
    check("stall_ready_back", 64'(a_in_ready), 64'(1));
    check("stall_data_b", 64'(a_out_data), 64'hBBBB);
    tick();
    drive_a(1'b0, 2'd0, D2, 16'h0, 1'b0);
    @(negedge clk);
    check("stall_data_c", 64'(a_out_data), 64'hCCCC);
    tick();

    // Bad select defaults to slice 0
    drive_a(1'b1, 2'd3, D3, 16'hBEEF, 1'b1);
    tick();
    drive_a(1'b0, 2'd0, D3, 16'h0, 1'b0);
    @(negedge clk);
    check("bad_data", 64'(a_out_data), 64'hBEEF);
    check("bad_err", 64'(a_out_sel_err), 64'(1));
    check("bad_count", 64'(a_err_count), 64'(1));
    tick();

    // Flush while both entries are full
    a_out_ready = 1'b0;
    drive_a(1'b1, 2'd0, D2, 16'hAAAA, 1'b0);
    tick();
    drive_a(1'b1, 2'd1, D2, 16'hBBBB, 1'b0);
    tick();
    a_flush = 1'b1;
    drive_a(1'b1, 2'd3, D3, 16'hBEEF, 1'b1);
    @(negedge clk);
    check("flush_ready", 64'(a_in_ready), 64'(0));
    tick();
    a_flush = 1'b0;
    drive_a(1'b0, 2'd0, D3, 16'h0, 1'b0);
    a_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(a_out_valid), 64'(0));
    check("flush_in_ready", 64'(a_in_ready), 64'(1));
    check("flush_err_count", 64'(a_err_count), 64'(1));
    a_out_ready = 1'b1;
    tick();
    tick();
    tick();

    // Saturation of the bad-select counter
    for (int i = 0; i < 300; i++) begin
      drive_a(1'b1, 2'd3, D3, 16'hBEEF, 1'b1);
      tick();
      if (i == 252) check("sat_count_254", 64'(a_err_count), 64'(254));
    end
    drive_a(1'b0, 2'd0, D3, 16'h0, 1'b0);
    @(negedge clk);
    check("sat_count_255", 64'(a_err_count), 64'(255));
    tick();
    tick();

    // Async reset mid-cycle with both entries full
    a_out_ready = 1'b0;
    drive_a(1'b1, 2'd0, D2, 16'hAAAA, 1'b0);
    tick();
    drive_a(1'b1, 2'd1, D2, 16'hBBBB, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(a_out_valid), 64'(0));
    check("arst_out_data", 64'(a_out_data), 64'(0));
    check("arst_err_count", 64'(a_err_count), 64'(0));
    check("arst_in_ready", 64'(a_in_ready), 64'(0));
    a_q.delete();
    b_q.delete();
    drive_a(1'b0, 2'd0, D1, 16'h0, 1'b0);
    @(negedge clk);
    check("arst_in_ready_hold", 64'(a_in_ready), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("arst_release_ready", 64'(a_in_ready), 64'(1));
    tick();
    a_out_ready = 1'b1;
    drive_a(1'b1, 2'd2, D1, 16'h3333, 1'b0);
    tick();
    drive_a(1'b0, 2'd0, D1, 16'h0, 1'b0);
    @(negedge clk);
    check("arst_first_valid", 64'(a_out_valid), 64'(1));
    check("arst_first_data", 64'(a_out_data), 64'h3333);
    tick();
    tick();
    check("a_drain", 64'(a_q.size()), 64'(0));

    // Random traffic on the 32-bit, 4-input instance
    new_beat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (new_beat) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_in_sel   = 2'($urandom_range(0, 3));
        for (int k = 0; k < int'(BN); k++) b_w[k] = $urandom;
        b_in_data  = {b_w[3], b_w[2], b_w[1], b_w[0]};
        b_exp_data = b_w[b_in_sel];
      end
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      new_beat = !b_in_valid || b_in_ready;
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (b_q.size() != 0) tick();
    end
    tick();
    check("b_drain", 64'(b_q.size()), 64'(0));
    check("b_traffic", 64'(b_acc_cnt > 50), 64'(1));
    check("b_err_count", 64'(b_err_count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
